// File: rtl/regfile_pkg.sv
// Shared defaults and port-slicing helper for the MIPS32 register file slice.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 2;

  // LSB of port 'port' within a flat bus of 'width'-bit lanes.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one reservation bit per register, issue arbitration
// and an incrementally maintained count of reserved registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  input  logic                    IssueValid,
  input  logic [ADDR_W-1:0]       IssueAddr,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       WriteAddr,
  input  logic                    Flush,
  output logic                    IssueAccept,
  output logic [(2**ADDR_W)-1:0]  pend,
  output logic [ADDR_W:0]         PendCount
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [NREGS-1:0] pend_reg, pend_next;
  logic [ADDR_W:0]  count_reg, count_next;
  logic             issue_hit, wb_same, set_en, clr_en, inc, dec;

  always_comb begin
    issue_hit   = pend_reg[IssueAddr];
    wb_same     = RegWrite && (WriteAddr == IssueAddr);
    IssueAccept = IssueValid && !Flush &&
                  ((IssueAddr == '0) || !issue_hit || wb_same);
    set_en      = IssueAccept && (IssueAddr != '0);
    clr_en      = RegWrite && (WriteAddr != '0);

    pend_next = pend_reg;
    if (clr_en) pend_next[WriteAddr] = 1'b0;
    if (set_en) pend_next[IssueAddr] = 1'b1;
    if (Flush)  pend_next = '0;

    // Count only real bit transitions so the counter tracks popcount exactly.
    inc = set_en && !issue_hit;
    dec = clr_en && pend_reg[WriteAddr] && !(set_en && (WriteAddr == IssueAddr));

    count_next = count_reg;
    if (Flush)             count_next = '0;
    else if (inc && !dec)  count_next = count_reg + CNT_ONE;
    else if (dec && !inc)  count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_reg  <= '0;
      count_reg <= '0;
    end else begin
      pend_reg  <= pend_next;
      count_reg <= count_next;
    end
  end

  assign pend      = pend_reg;
  assign PendCount = count_reg;

endmodule

// File: rtl/regfile_sb.sv
// MIPS32 register file: NREAD combinational read ports with optional
// write-to-read bypass, one write-back port, and a pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      Reset_n,
  input  logic [NREAD*ADDR_W-1:0]   ReadAddr,
  output logic [NREAD*DATA_W-1:0]   ReadData,
  output logic [NREAD-1:0]          ReadPending,
  input  logic                      IssueValid,
  input  logic [ADDR_W-1:0]         IssueAddr,
  output logic                      IssueAccept,
  input  logic                      RegWrite,
  input  logic [ADDR_W-1:0]         WriteAddr,
  input  logic [DATA_W-1:0]         WriteData,
  input  logic                      Flush,
  output logic [ADDR_W:0]           PendCount
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem_reg [NREGS];
  logic [NREGS-1:0]  pend;

  // Entry 0 is reset and never written, so it always reads as zero.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) mem_reg[i] <= '0;
    end else if (RegWrite && (WriteAddr != '0)) begin
      mem_reg[WriteAddr] <= WriteData;
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .IssueValid  (IssueValid),
    .IssueAddr   (IssueAddr),
    .RegWrite    (RegWrite),
    .WriteAddr   (WriteAddr),
    .Flush       (Flush),
    .IssueAccept (IssueAccept),
    .pend        (pend),
    .PendCount   (PendCount)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      localparam int ALSB = port_lsb(gi, ADDR_W);
      localparam int DLSB = port_lsb(gi, DATA_W);
      logic [ADDR_W-1:0] raddr;
      logic              wb_hit;

      assign raddr  = ReadAddr[ALSB +: ADDR_W];
      assign wb_hit = (BYPASS != 0) && RegWrite && (WriteAddr == raddr);
      assign ReadData[DLSB +: DATA_W] =
        (wb_hit && (raddr != '0)) ? WriteData : mem_reg[raddr];
      // A write-back landing this cycle releases the operand when bypassing.
      assign ReadPending[gi] = pend[raddr] && !wb_hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default parameters, BYPASS=1) with a short
// randomised scoreboard run against a bit-vector model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  ReadAddr;
  logic [63:0] ReadData;
  logic [1:0]  ReadPending;
  logic        IssueValid;
  logic [4:0]  IssueAddr;
  logic        IssueAccept;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        Flush;
  logic [5:0]  PendCount;

  int total = 0;
  int bad   = 0;

  logic [31:0] pend_m;
  logic        exp_acc;
  logic        exp_rp;

  regfile_sb dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .ReadPending (ReadPending),
    .IssueValid  (IssueValid),
    .IssueAddr   (IssueAddr),
    .IssueAccept (IssueAccept),
    .RegWrite    (RegWrite),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .Flush       (Flush),
    .PendCount   (PendCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IssueValid = 1'b0; IssueAddr = '0; RegWrite = 1'b0;
    WriteAddr = '0; WriteData = '0; Flush = 1'b0;
  endtask

  function automatic logic [31:0] rd(input int k);
    return ReadData[k*32 +: 32];
  endfunction

  initial begin
    Reset_n = 1'b0; ReadAddr = '0; idle();
    #2;
    chk("rst_data0", rd(0), 32'h0);
    chk("rst_pend", ReadPending, 2'b00);
    chk("rst_count", PendCount, 6'd0);
    @(negedge clk); Reset_n = 1'b1;
    tick();

    // Writes to register 0 are dropped; issuing 0 is accepted with no effect
    RegWrite = 1; WriteAddr = 0; WriteData = 32'hFFFF_FFFF;
    ReadAddr = {5'd0, 5'd0}; IssueValid = 1; IssueAddr = 0;
    #1;
    chk("r0_bypass", rd(0), 32'h0);
    chk("r0_accept", IssueAccept, 1'b1);
    tick(); idle(); #1;
    chk("r0_data", rd(0), 32'h0);
    chk("r0_count", PendCount, 6'd0);

    // Same-cycle write is visible on port 1
    RegWrite = 1; WriteAddr = 7; WriteData = 32'h1111_1111;
    tick();
    WriteData = 32'hDEAD_BEEF; ReadAddr = {5'd7, 5'd0};
    #1;
    chk("bypass_r7", rd(1), 32'hDEAD_BEEF);
    tick(); idle(); #1;
    chk("stored_r7", rd(1), 32'hDEAD_BEEF);

    // Reservation, WAW refusal, write-back together with reissue
    ReadAddr = {5'd0, 5'd3}; IssueValid = 1; IssueAddr = 3;
    #1;
    chk("iss3_accept", IssueAccept, 1'b1);
    tick(); idle(); #1;
    chk("iss3_pending", ReadPending[0], 1'b1);
    chk("iss3_count", PendCount, 6'd1);
    IssueValid = 1; IssueAddr = 3; #1;
    chk("waw_refuse", IssueAccept, 1'b0);
    tick(); #1;
    chk("waw_count", PendCount, 6'd1);
    RegWrite = 1; WriteAddr = 3; WriteData = 32'h33; #1;
    chk("wb_iss_accept", IssueAccept, 1'b1);
    chk("wb_release", ReadPending[0], 1'b0);
    chk("wb_bypass3", rd(0), 32'h33);
    tick(); idle(); #1;
    chk("reiss3_pending", ReadPending[0], 1'b1);
    chk("reiss3_count", PendCount, 6'd1);
    RegWrite = 1; WriteAddr = 3; WriteData = 32'h34;
    tick(); idle(); #1;
    chk("wb3_pending", ReadPending[0], 1'b0);
    chk("wb3_count", PendCount, 6'd0);

    // Set and clear on different registers net to zero; clearing a clear bit is free
    IssueValid = 1; IssueAddr = 10;
    tick(); idle();
    IssueValid = 1; IssueAddr = 11; RegWrite = 1; WriteAddr = 10;
    tick(); idle(); #1;
    chk("swap_count", PendCount, 6'd1);
    RegWrite = 1; WriteAddr = 12;
    tick(); idle(); #1;
    chk("clr_clear_cnt", PendCount, 6'd1);
    RegWrite = 1; WriteAddr = 11;
    tick(); idle(); #1;
    chk("drain_count", PendCount, 6'd0);

    // Asynchronous reset in the middle of a cycle
    RegWrite = 1; WriteAddr = 5; WriteData = 32'h1234; IssueValid = 1; IssueAddr = 5;
    tick(); idle(); ReadAddr = {5'd5, 5'd5}; #1;
    chk("pre_rst_data", rd(1), 32'h1234);
    chk("pre_rst_pend", ReadPending, 2'b11);
    chk("pre_rst_count", PendCount, 6'd1);
    #1 Reset_n = 1'b0;
    #1;
    chk("async_data", rd(1), 32'h0);
    chk("async_pend", ReadPending, 2'b00);
    chk("async_count", PendCount, 6'd0);
    @(negedge clk); Reset_n = 1'b1;
    tick();

    // Fill every register, then flush
    for (int i = 1; i < 32; i++) begin
      IssueValid = 1; IssueAddr = 5'(i);
      tick();
    end
    idle(); #1;
    chk("full_count", PendCount, 6'd31);
    ReadAddr = {5'd31, 5'd1}; #1;
    chk("full_pending", ReadPending, 2'b11);
    Flush = 1; IssueValid = 1; IssueAddr = 0; #1;
    chk("flush_refuse", IssueAccept, 1'b0);
    tick(); idle(); #1;
    chk("flush_count", PendCount, 6'd0);
    chk("flush_pending", ReadPending, 2'b00);

    // Random issue/write-back against a reservation-bit model
    pend_m = '0;
    for (int n = 0; n < 150; n++) begin
      IssueValid = 1'($urandom_range(0, 1));
      IssueAddr  = 5'($urandom_range(0, 31));
      RegWrite   = 1'($urandom_range(0, 1));
      WriteAddr  = 5'($urandom_range(0, 31));
      WriteData  = $urandom;
      Flush      = ($urandom_range(0, 19) == 0);
      ReadAddr   = 10'($urandom);
      #1;
      exp_acc = IssueValid && !Flush &&
                (IssueAddr == 0 || !pend_m[IssueAddr] || (RegWrite && WriteAddr == IssueAddr));
      exp_rp  = pend_m[ReadAddr[4:0]] && !(RegWrite && WriteAddr == ReadAddr[4:0]);
      chk("rnd_accept", IssueAccept, exp_acc);
      chk("rnd_rpend", ReadPending[0], exp_rp);
      if (Flush) pend_m = '0;
      else begin
        if (RegWrite && WriteAddr != 0) pend_m[WriteAddr] = 1'b0;
        if (exp_acc && IssueAddr != 0) pend_m[IssueAddr] = 1'b1;
      end
      tick();
      chk("rnd_count", PendCount, 64'($countones(pend_m)));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
